// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared types and constants for the LED pattern generator
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_MIRROR  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int PWM_W = 8;

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - 2-FF synchroniser plus stability counter for one switch bit
module sw_debounce #(
    parameter int DEB_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic sw_deb
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronised level matches the debounced one restarts the count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sw_deb = deb_q;

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - debounced switch control of COUNT/SCAN/BREATHE/MIRROR LED patterns
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int N_LEDS     = 4,
    parameter int N_SW       = 4,
    parameter int CNT_W      = 16,
    parameter int DEB_CYCLES = 1024
) (
    input  logic              board_clk,
    input  logic              board_rst,
    input  logic [N_SW-1:0]   switches,
    output logic [N_LEDS-1:0] leds,
    output logic              tick
);

    localparam int PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [PW-1:0] POS_LAST = PW'(N_LEDS - 1);

    logic [N_SW-1:0] deb_sw;

    for (genvar i = 0; i < N_SW; i++) begin : g_deb
        sw_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk   (board_clk),
            .rst   (board_rst),
            .sw_in (switches[i]),
            .sw_deb(deb_sw[i])
        );
    end

    mode_e       mode;
    logic [1:0]  rate;
    logic [CNT_W-1:0] tick_mask;

    assign mode      = mode_e'(deb_sw[1:0]);
    assign rate      = deb_sw[3:2];
    assign tick_mask = {CNT_W{1'b1}} >> {rate, 1'b0};

    logic [CNT_W-1:0]  presc_q, presc_d;
    logic              tick_q, tick_d;
    mode_e             mode_q, mode_d;
    logic [N_LEDS-1:0] count_q, count_d;
    logic [PW-1:0]     pos_q, pos_d;
    dir_e              scan_dir_q, scan_dir_d;
    logic [PWM_W-1:0]  duty_q, duty_d;
    dir_e              breathe_dir_q, breathe_dir_d;
    logic [N_LEDS-1:0] leds_q, leds_d;

    always_comb begin
        presc_d       = presc_q + CNT_W'(1);
        tick_d        = ((presc_q & tick_mask) == tick_mask);
        mode_d        = mode;
        count_d       = count_q;
        pos_d         = pos_q;
        scan_dir_d    = scan_dir_q;
        duty_d        = duty_q;
        breathe_dir_d = breathe_dir_q;

        // A mode change swallows a coincident tick so every pattern starts from its origin.
        if (mode != mode_q) begin
            count_d       = '0;
            pos_d         = '0;
            scan_dir_d    = DIR_UP;
            duty_d        = '0;
            breathe_dir_d = DIR_UP;
        end else if (tick_q) begin
            unique case (mode)
                MODE_COUNT: count_d = count_q + N_LEDS'(1);
                MODE_SCAN: begin
                    if (N_LEDS > 1) begin
                        if (scan_dir_q == DIR_UP) begin
                            pos_d = pos_q + PW'(1);
                            if (pos_d == POS_LAST) scan_dir_d = DIR_DOWN;
                        end else begin
                            pos_d = pos_q - PW'(1);
                            if (pos_d == '0) scan_dir_d = DIR_UP;
                        end
                    end
                end
                MODE_BREATHE: begin
                    if (breathe_dir_q == DIR_UP) begin
                        duty_d = duty_q + PWM_W'(1);
                        if (duty_d == '1) breathe_dir_d = DIR_DOWN;
                    end else begin
                        duty_d = duty_q - PWM_W'(1);
                        if (duty_d == '0) breathe_dir_d = DIR_UP;
                    end
                end
                MODE_MIRROR: ;
            endcase
        end

        leds_d = '0;
        unique case (mode)
            MODE_COUNT:   leds_d = count_q;
            MODE_SCAN:    leds_d = N_LEDS'(1) << pos_q;
            MODE_BREATHE: leds_d = {N_LEDS{presc_q[PWM_W-1:0] < duty_q}};
            MODE_MIRROR:  leds_d = N_LEDS'(deb_sw);
        endcase
    end

    always_ff @(posedge board_clk or posedge board_rst) begin
        if (board_rst) begin
            presc_q       <= '0;
            tick_q        <= 1'b0;
            mode_q        <= MODE_COUNT;
            count_q       <= '0;
            pos_q         <= '0;
            scan_dir_q    <= DIR_UP;
            duty_q        <= '0;
            breathe_dir_q <= DIR_UP;
            leds_q        <= '0;
        end else begin
            presc_q       <= presc_d;
            tick_q        <= tick_d;
            mode_q        <= mode_d;
            count_q       <= count_d;
            pos_q         <= pos_d;
            scan_dir_q    <= scan_dir_d;
            duty_q        <= duty_d;
            breathe_dir_q <= breathe_dir_d;
            leds_q        <= leds_d;
        end
    end

    assign leds = leds_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - directed self-checking bench for led_pattern_gen
module tb_led_pattern_gen;

    localparam int N_LEDS     = 4;
    localparam int N_SW       = 4;
    localparam int CNT_W      = 8;
    localparam int DEB_CYCLES = 4;

    logic              board_clk = 1'b0;
    logic              board_rst = 1'b0;
    logic [N_SW-1:0]   switches  = '0;
    logic [N_LEDS-1:0] leds;
    logic              tick;

    int tests = 0;
    int fails = 0;

    led_pattern_gen #(
        .N_LEDS    (N_LEDS),
        .N_SW      (N_SW),
        .CNT_W     (CNT_W),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .board_clk(board_clk),
        .board_rst(board_rst),
        .switches (switches),
        .leds     (leds),
        .tick     (tick)
    );

    always #5 board_clk = ~board_clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge board_clk);
            cyc++;
        end while (tick !== 1'b1 && cyc < 2000);
        if (tick !== 1'b1) check("tick_timeout", 32'(tick), 32'd1);
    endtask

    task automatic step(input string name, input logic [3:0] exp_leds, input int exp_gap);
        int cyc;
        wait_tick(cyc);
        if (exp_gap > 0) check({name, "_gap"}, 32'(cyc), 32'(exp_gap));
        repeat (2) @(negedge board_clk);
        check(name, 32'(leds), 32'(exp_leds));
    endtask

    task automatic pwm_window(input string name, input int exp_high);
        int high = 0;
        int bad  = 0;
        for (int s = 0; s < 256; s++) begin
            @(negedge board_clk);
            if (leds === 4'hF) high++;
            else if (leds !== 4'h0) bad++;
        end
        check({name, "_high"}, 32'(high), 32'(exp_high));
        check({name, "_uniform"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] n;
        logic [3:0] scan_exp [6];
        int cyc;
        int bad;
        int ticks;

        board_rst = 1'b1;
        repeat (3) @(negedge board_clk);
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        board_rst = 1'b0;

        // COUNT at rate 0: first tick 256 cycles after release, then every 256.
        step("count_1", 4'd1, 256);
        for (int i = 2; i <= 16; i++) begin
            n = 4'(i);
            step($sformatf("count_%0d", i), n, 254);
        end

        // 3-cycle glitch must not reach the debounced value.
        switches = 4'b0001;
        repeat (3) @(negedge board_clk);
        switches = 4'b0000;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge board_clk);
            if (leds !== 4'b0000) bad++;
        end
        check("glitch_no_mode", 32'(bad), 32'd0);

        switches = 4'b0001;
        repeat (7) @(negedge board_clk);
        check("scan_init", 32'(leds), 32'b0001);
        scan_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        for (int i = 0; i < 6; i++) begin
            step($sformatf("scan_%0d", i), scan_exp[i], (i == 0) ? 0 : 254);
        end

        // COUNT rate 3, then rate 1 mid-count without disturbing the count.
        switches = 4'b1100;
        repeat (6) @(negedge board_clk);
        n = 4'd0;
        for (int i = 0; i < 4; i++) begin
            n++;
            step($sformatf("fast_%0d", i), n, (i == 0) ? 0 : 2);
        end
        switches = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            n++;
            step($sformatf("rate1_%0d", i), n, (i >= 3) ? 62 : 0);
        end

        // COUNT (9) -> MIRROR -> COUNT.
        switches = 4'b0011;
        repeat (6) @(negedge board_clk);
        check("mirror_pre", 32'(leds), 32'd9);
        @(negedge board_clk);
        check("mirror_on", 32'(leds), 32'b0011);
        switches = 4'b0000;
        repeat (6) @(negedge board_clk);
        check("mirror_hold", 32'(leds), 32'b0011);
        @(negedge board_clk);
        check("count_reload", 32'(leds), 32'd0);

        // BREATHE rate 3 up to 255 and back down, then rate 0 to measure duty.
        switches = 4'b1110;
        repeat (6) @(negedge board_clk);
        ticks = 0;
        while (ticks < 376) begin
            wait_tick(cyc);
            ticks++;
        end
        switches = 4'b0010;
        while (ticks < 382) begin
            wait_tick(cyc);
            ticks++;
        end
        @(negedge board_clk);
        pwm_window("duty128", 128);
        pwm_window("duty127", 127);

        // SCAN rate 3, then a one-cycle reset mid-pattern.
        switches = 4'b1101;
        repeat (6) @(negedge board_clk);
        step("rscan_0", 4'b0010, 0);
        step("rscan_1", 4'b0100, 2);
        step("rscan_2", 4'b1000, 2);
        @(negedge board_clk);
        board_rst = 1'b1;
        #1;
        check("midrst_leds", 32'(leds), 32'd0);
        check("midrst_tick", 32'(tick), 32'd0);
        @(negedge board_clk);
        board_rst = 1'b0;
        repeat (6) @(negedge board_clk);
        check("post_rst_count", 32'(leds), 32'd0);
        @(negedge board_clk);
        check("post_rst_scan", 32'(leds), 32'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
Parameters, one per line: name, default, meaning.
REQ-001 The block SHALL have parameter N_LEDS, default 4, which sets the LED output width (at least 1).
REQ-002 The block SHALL have parameter N_SW, default 4, which sets the switch input width (at least 4).
REQ-003 The block SHALL have parameter CNT_W, default 16, which sets the prescaler width (at least 8).
REQ-004 The block SHALL have parameter DEB_CYCLES, default 1024, which sets the number of consecutive stable cycles a debounced switch needs (at least 2).

Ports, one per line: name, direction, width, meaning.
REQ-005 board_clk, input, 1: the single clock; all state SHALL be clocked on its rising edge.
REQ-006 board_rst, input, 1: reset, asynchronous and active-high.
REQ-007 switches, input, N_SW: raw, asynchronous, bouncing switch levels.
REQ-008 leds, output, N_LEDS: registered LED drive.
REQ-009 tick, output, 1: registered one-cycle prescaler strobe.

Function
REQ-010 Each switch bit SHALL pass through a 2-FF synchroniser; the debounced value SHALL update only after the synchronised value has differed from it for DEB_CYCLES consecutive cycles.
- Any return to the current debounced value SHALL restart that bit's stability count.
REQ-011 Control fields:
- mode = deb_sw[1:0], with 0 COUNT, 1 SCAN, 2 BREATHE, 3 MIRROR.
- rate = deb_sw[3:2].
REQ-012 The prescaler SHALL be a free-running CNT_W-bit counter that wraps.
- tick SHALL be 1 in the cycle after the low (CNT_W-2*rate) prescaler bits are all ones, giving a period of 2^(CNT_W-2*rate) cycles.
REQ-013 COUNT: an N_LEDS-bit counter SHALL increment on each tick and wrap from all-ones to 0; leds = counter.
REQ-014 SCAN: the pattern SHALL be a one-hot position with a direction state of UP or DOWN.
- On tick in UP: position+1; on reaching N_LEDS-1 the direction SHALL become DOWN.
- On tick in DOWN: position-1; on reaching 0 the direction SHALL become UP.
- With N_LEDS=1, leds[0] SHALL stay 1.
REQ-015 BREATHE: an 8-bit duty and a direction SHALL update on tick.
- Duty SHALL rise to 255, then fall to 0, then repeat; it SHALL never wrap.
- All leds SHALL equal (prescaler[7:0] < duty), so duty 0 gives off and duty 255 gives on in 255 of every 256 cycles.
REQ-016 MIRROR: leds SHALL equal deb_sw, zero-extended or truncated to N_LEDS.
REQ-017 leds SHALL be registered, with one cycle of latency from the pattern state.
REQ-018 When the debounced mode changes, all pattern state SHALL reload its initial value on the next edge:
- count 0;
- position 0 with direction UP;
- duty 0 with direction UP.
REQ-019 A mode change in the same cycle as tick SHALL take priority; that tick SHALL NOT advance the pattern.
REQ-020 A rate change SHALL NOT reset the prescaler or the pattern state.

Reset
REQ-021 Asserting board_rst SHALL immediately clear:
- leds and tick;
- prescaler, debounce counters and debounced values;
- synchronisers and all pattern state.
REQ-022 After reset the debounced switches SHALL be 0, giving COUNT mode at rate 0.
REQ-023 Reset asserted mid-pattern SHALL abandon the pattern with no residual state.
REQ-024 Release of board_rst SHALL be synchronised externally.

Structure
REQ-025 Package led_pattern_pkg SHALL hold:
- the mode enum (MODE_COUNT, MODE_SCAN, MODE_BREATHE, MODE_MIRROR);
- the scan and breathe direction enum;
- the 8-bit PWM width constant.
REQ-026 Sub-module sw_debounce SHALL be instantiated once per switch bit and SHALL contain the synchroniser and the stability counter.
- Its count width SHALL be $clog2(DEB_CYCLES+1).

Verification
Bench parameters: N_LEDS=4, CNT_W=8, DEB_CYCLES=4.
REQ-027 Reset with switches=0 -> leds=0 and tick=0 during reset; after release, the first tick arrives after 256 cycles and leds steps 1, 2, ..., 15, 0 on successive ticks.
REQ-028 Glitch test: switches=4'b0001 held 3 cycles, then 0 -> no mode change; held 6 cycles -> SCAN; leds = 0001, 0010, 0100, 1000, 0100, 0010, 0001 on successive ticks.
REQ-029 switches=4'b1100 (COUNT, rate 3) -> tick period 4 cycles; switch to rate 1 mid-count -> count continues with no reset and period becomes 64.
REQ-030 switches=4'b1110 (BREATHE, rate 3) -> duty reaches 255 after 255 ticks, then falls; at duty 128, leds high for exactly 128 of each 256 cycles.
REQ-031 Mode change from COUNT (count=9) to MIRROR coinciding with tick -> leds=4'b0011 one cycle after debounce, with no count increment; returning to COUNT gives leds=0.
REQ-032 board_rst pulsed for 1 cycle mid-SCAN -> leds=0 immediately; debounce restarts and the block returns to COUNT.
